// File: rtl/wb_lsu_pkg.sv
// Shared types for the LSU Wishbone master: access sizes, FSM states, error bits.
package wb_lsu_pkg;

  typedef enum logic [1:0] {
    SIZE_B    = 2'b00,
    SIZE_H    = 2'b01,
    SIZE_W    = 2'b10,
    SIZE_RSVD = 2'b11
  } lsu_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUS  = 2'b01,
    RESP = 2'b10
  } lsu_state_e;

  // Response error vector is {timeout, bus_err, misaligned}.
  localparam logic [2:0] ERR_NONE     = 3'b000;
  localparam logic [2:0] ERR_MISALIGN = 3'b001;
  localparam logic [2:0] ERR_BUS      = 3'b010;
  localparam logic [2:0] ERR_TIMEOUT  = 3'b100;

  function automatic logic is_misaligned(input lsu_size_e size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SIZE_B:  mis = 1'b0;
      SIZE_H:  mis = addr_lo[0];
      SIZE_W:  mis = (addr_lo != 2'b00);
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/wb_bus_t.sv
// Classic single-cycle Wishbone bus between the LSU master and the RAM wrapper slave.
interface wb_bus_t #(
  parameter int unsigned ADDR_W = 32
);
  logic              cyc;
  logic              stb;
  logic              we;
  logic [3:0]        sel;
  logic [ADDR_W-1:0] adr;
  logic [31:0]       dat_w;
  logic [31:0]       dat_r;
  logic              ack;
  logic              err;

  modport master (
    output cyc, stb, we, sel, adr, dat_w,
    input  dat_r, ack, err
  );

  modport slave (
    input  cyc, stb, we, sel, adr, dat_w,
    output dat_r, ack, err
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: sel/write replication outbound, lane extract + sign/zero extend inbound.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the owner decides when the results are sampled.
module lsu_lane_align
  import wb_lsu_pkg::*;
(
  input  logic [1:0]  wr_addr_lo,
  input  lsu_size_e   wr_size,
  input  logic [31:0] wr_data,
  output logic [3:0]  sel,
  output logic [31:0] wr_dat,
  input  logic [1:0]  rd_addr_lo,
  input  lsu_size_e   rd_size,
  input  logic        rd_unsigned,
  input  logic [31:0] rd_dat,
  output logic [31:0] rd_data
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  // Narrow stores are replicated so any lane the slave samples holds the datum.
  always_comb begin
    sel    = 4'b1111;
    wr_dat = wr_data;
    case (wr_size)
      SIZE_B: begin
        sel    = 4'b0001 << wr_addr_lo;
        wr_dat = {4{wr_data[7:0]}};
      end
      SIZE_H: begin
        sel    = 4'b0011 << wr_addr_lo;
        wr_dat = {2{wr_data[15:0]}};
      end
      default: ;
    endcase
  end

  assign rd_byte = rd_dat[{rd_addr_lo, 3'b000} +: 8];
  assign rd_half = rd_dat[{rd_addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    rd_data = rd_dat;
    case (rd_size)
      SIZE_B:  rd_data = {{24{~rd_unsigned & rd_byte[7]}}, rd_byte};
      SIZE_H:  rd_data = {{16{~rd_unsigned & rd_half[15]}}, rd_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/wb_lsu_master.sv
// LSU-to-Wishbone adapter: one classic single cycle per request, errors reported in the response.
// Latency: zero-wait slave gives cyc at T+1 and rsp_valid at T+2; misaligned responds at T+1.
// Backpressure: req_ready low in BUS/RESP; response held stable until rsp_ready.
module wb_lsu_master
  import wb_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic              req_we_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [31:0]       req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [31:0]       rsp_rdata_o,
  output logic [2:0]        rsp_err_o,
  wb_bus_t.master           wb_bus
);

  localparam int unsigned      CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  lsu_state_e        state_q, state_d;
  lsu_size_e         req_size;
  lsu_size_e         size_q;
  logic [1:0]        addr_lo_q;
  logic              uns_q;
  logic              cyc_q;
  logic              we_q;
  logic [3:0]        sel_q;
  logic [ADDR_W-1:0] adr_q;
  logic [31:0]       dat_q;
  logic [31:0]       rdata_q;
  logic [2:0]        err_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [3:0]        lane_sel;
  logic [31:0]       lane_wdat;
  logic [31:0]       lane_rdat;
  logic              accept;
  logic              misaligned;
  logic              timeout_hit;

  assign req_size    = lsu_size_e'(req_size_i);
  assign misaligned  = is_misaligned(req_size, req_addr_i[1:0]);
  assign accept      = req_valid_i & req_ready_o;
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

  lsu_lane_align u_lane (
    .wr_addr_lo  (req_addr_i[1:0]),
    .wr_size     (req_size),
    .wr_data     (req_wdata_i),
    .sel         (lane_sel),
    .wr_dat      (lane_wdat),
    .rd_addr_lo  (addr_lo_q),
    .rd_size     (size_q),
    .rd_unsigned (uns_q),
    .rd_dat      (wb_bus.dat_r),
    .rd_data     (lane_rdat)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          state_d = misaligned ? RESP : BUS;
        end
      end
      BUS: begin
        if (wb_bus.err || wb_bus.ack || timeout_hit) begin
          state_d = RESP;
        end
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus fields only load for aligned requests, so a misaligned access never disturbs the bus.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      size_q    <= SIZE_B;
      addr_lo_q <= 2'b00;
      uns_q     <= 1'b0;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      sel_q     <= 4'b0000;
      adr_q     <= '0;
      dat_q     <= '0;
      rdata_q   <= '0;
      err_q     <= ERR_NONE;
      cnt_q     <= '0;
    end else if (accept) begin
      size_q    <= req_size;
      addr_lo_q <= req_addr_i[1:0];
      uns_q     <= req_unsigned_i;
      cnt_q     <= '0;
      if (misaligned) begin
        rdata_q <= '0;
        err_q   <= ERR_MISALIGN;
      end else begin
        cyc_q <= 1'b1;
        we_q  <= req_we_i;
        sel_q <= lane_sel;
        adr_q <= {req_addr_i[ADDR_W-1:2], 2'b00};
        dat_q <= lane_wdat;
      end
    end else if (state_q == BUS) begin
      cnt_q <= cnt_q + 1'b1;
      // err outranks ack; a late ack on the last counted cycle still beats the timeout.
      if (wb_bus.err) begin
        cyc_q   <= 1'b0;
        rdata_q <= '0;
        err_q   <= ERR_BUS;
      end else if (wb_bus.ack) begin
        cyc_q   <= 1'b0;
        rdata_q <= we_q ? 32'h0 : lane_rdat;
        err_q   <= ERR_NONE;
      end else if (timeout_hit) begin
        cyc_q   <= 1'b0;
        rdata_q <= '0;
        err_q   <= ERR_TIMEOUT;
      end
    end
  end

  assign wb_bus.cyc   = cyc_q;
  assign wb_bus.stb   = cyc_q;
  assign wb_bus.we    = we_q;
  assign wb_bus.sel   = sel_q;
  assign wb_bus.adr   = adr_q;
  assign wb_bus.dat_w = dat_q;

  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_wb_lsu_master.sv
// Randomized bench for wb_lsu_master: byte-level memory model, per-cycle bus/response compare.
module tb_wb_lsu_master;

  localparam int TO = 8;

  logic        clk;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  logic        req_we_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic [2:0]  rsp_err_o;

  wb_bus_t #(.ADDR_W(32)) bus ();

  wb_lsu_master #(.TIMEOUT(TO), .ADDR_W(32)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_addr_i     (req_addr_i),
    .req_we_i       (req_we_i),
    .req_size_i     (req_size_i),
    .req_unsigned_i (req_unsigned_i),
    .req_wdata_i    (req_wdata_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_ready_i    (rsp_ready_i),
    .rsp_rdata_o    (rsp_rdata_o),
    .rsp_err_o      (rsp_err_o),
    .wb_bus         (bus)
  );

  int checks = 0;
  int errors = 0;

  // Slave behaviour: 0 RAM with slave_wait wait states, 1 err, 2 silent, 3 ack+err together.
  int         slave_mode = 0;
  int         slave_wait = 0;
  int         wait_cnt   = 0;
  logic       stray_ack  = 1'b0;
  logic       stray_err  = 1'b0;
  logic [31:0] mem [0:63];
  logic [7:0]  ref_mem [0:255];

  logic [31:0] exp_adr, exp_dat, exp_rd;
  logic [3:0]  exp_sel;
  logic        exp_we;
  logic [2:0]  exp_err;
  int          exp_lat, exp_cyc;
  logic        txn_active = 1'b0;
  int          cyc_total = 0;
  logic [3:0]  seen_sel;
  logic [31:0] seen_dat, seen_adr;
  logic [31:0] last_rdata;
  logic [2:0]  last_err;
  int          last_lat, last_cyc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign bus.ack = stray_ack | (bus.cyc & bus.stb &
                   ((slave_mode == 0 && wait_cnt == slave_wait) || slave_mode == 3));
  assign bus.err = stray_err | (bus.cyc & bus.stb & (slave_mode == 1 || slave_mode == 3));
  assign bus.dat_r = mem[bus.adr[7:2]];

  always @(posedge clk) begin
    wait_cnt <= bus.cyc ? wait_cnt + 1 : 0;
    if (bus.cyc && bus.stb && bus.we && bus.ack && !bus.err) begin
      for (int l = 0; l < 4; l++) begin
        if (bus.sel[l]) mem[bus.adr[7:2]][8*l +: 8] <= bus.dat_w[8*l +: 8];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected outcome of one request, derived from access rules and a byte-addressed memory.
  task automatic model(input logic [31:0] a, input logic we, input logic [1:0] sz,
                       input logic uns, input logic [31:0] wd);
    int n;
    logic [31:0] v;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    exp_rd  = 32'h0;
    exp_adr = {a[31:2], 2'b00};
    exp_we  = we;
    exp_sel = 4'b0000;
    exp_dat = 32'h0;
    if (sz == 2'd3 || (int'(a[1:0]) % n) != 0) begin
      exp_lat = 1;
      exp_cyc = 0;
      exp_err = 3'b001;
      return;
    end
    for (int i = 0; i < n; i++) exp_sel[(int'(a[1:0]) + i) % 4] = 1'b1;
    for (int l = 0; l < 4; l++) exp_dat[8*l +: 8] = wd[8*(l % n) +: 8];
    if (slave_mode == 1 || slave_mode == 3) begin
      exp_lat = 2;
      exp_cyc = 1;
      exp_err = 3'b010;
    end else if (slave_mode == 2 || slave_wait >= TO) begin
      exp_lat = TO + 1;
      exp_cyc = TO;
      exp_err = 3'b100;
    end else begin
      exp_lat = 2 + slave_wait;
      exp_cyc = 1 + slave_wait;
      exp_err = 3'b000;
      if (we) begin
        for (int i = 0; i < n; i++) ref_mem[int'(a[7:0]) + i] = wd[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[int'(a[7:0]) + i];
        if (!uns && n < 4 && v[8*n-1]) begin
          for (int b = 8*n; b < 32; b++) v[b] = 1'b1;
        end
        exp_rd = v;
      end
    end
  endtask

  // Per-cycle compare, sampled 1ns after the rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst_i) begin
        chk("cyc_eq_stb", bus.stb, bus.cyc);
        if (bus.cyc) begin
          cyc_total++;
          chk("cyc_without_txn", txn_active, 1'b1);
          chk("ready_low_in_bus", req_ready_o, 1'b0);
          chk("bus_adr", bus.adr, exp_adr);
          chk("bus_sel", bus.sel, exp_sel);
          chk("bus_we", bus.we, exp_we);
          chk("bus_dat", bus.dat_w, exp_dat);
          seen_sel = bus.sel;
          seen_dat = bus.dat_w;
          seen_adr = bus.adr;
        end
        if (rsp_valid_o) begin
          chk("rsp_without_txn", txn_active, 1'b1);
          chk("rsp_rdata", rsp_rdata_o, exp_rd);
          chk("rsp_err", rsp_err_o, exp_err);
        end
      end
    end
  end

  // One full request/response exchange; called at a falling edge, returns at a falling edge.
  task automatic do_req(input logic [31:0] a, input logic we, input logic [1:0] sz,
                        input logic uns, input logic [31:0] wd, input int hold);
    int guard;
    int lat;
    int cyc_start;
    guard = 0;
    while (!req_ready_o && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("req_ready_idle", req_ready_o, 1'b1);
    model(a, we, sz, uns, wd);
    req_valid_i    = 1'b1;
    req_addr_i     = a;
    req_we_i       = we;
    req_size_i     = sz;
    req_unsigned_i = uns;
    req_wdata_i    = wd;
    txn_active     = 1'b1;
    cyc_start      = cyc_total;
    @(negedge clk);
    req_valid_i = 1'b0;
    lat = 1;
    while (!rsp_valid_o && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    last_lat   = lat;
    last_cyc   = cyc_total - cyc_start;
    last_rdata = rsp_rdata_o;
    last_err   = rsp_err_o;
    chk("rsp_latency", lat, exp_lat);
    chk("cyc_cycles", last_cyc, exp_cyc);
    for (int i = 0; i < hold; i++) begin
      chk("ready_low_in_resp", req_ready_o, 1'b0);
      @(negedge clk);
    end
    rsp_ready_i = 1'b1;
    @(negedge clk);
    rsp_ready_i = 1'b0;
    txn_active  = 1'b0;
    chk("rsp_dropped", rsp_valid_o, 1'b0);
    chk("ready_back", req_ready_o, 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  initial begin
    int rsp_seen;
    int r;
    logic [1:0] sz;
    rst_i          = 1'b1;
    req_valid_i    = 1'b0;
    req_addr_i     = 32'h0;
    req_we_i       = 1'b0;
    req_size_i     = 2'd0;
    req_unsigned_i = 1'b0;
    req_wdata_i    = 32'h0;
    rsp_ready_i    = 1'b0;
    #3;
    chk("rst_req_ready", req_ready_o, 1'b1);
    chk("rst_rsp_valid", rsp_valid_o, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata_o, 32'h0);
    chk("rst_rsp_err", rsp_err_o, 3'b000);
    chk("rst_cyc", bus.cyc, 1'b0);
    chk("rst_stb", bus.stb, 1'b0);
    chk("rst_we", bus.we, 1'b0);
    chk("rst_sel", bus.sel, 4'b0000);
    chk("rst_adr", bus.adr, 32'h0);
    chk("rst_dat", bus.dat_w, 32'h0);
    @(negedge clk);
    rst_i = 1'b0;

    // Fill memory through the DUT so bench RAM and model start identical.
    for (int w = 0; w < 64; w++) do_req(32'(w * 4), 1'b1, 2'd2, 1'b0, $urandom, 0);

    do_req(32'h10, 1'b1, 2'd2, 1'b0, 32'hDEADBEEF, 0);
    chk("st_word_sel", seen_sel, 4'b1111);
    chk("st_word_adr", seen_adr, 32'h10);
    chk("st_word_err", last_err, 3'b000);
    do_req(32'h10, 1'b0, 2'd2, 1'b0, 32'h0, 0);
    chk("ld_word_data", last_rdata, 32'hDEADBEEF);
    chk("ld_word_lat", last_lat, 2);

    do_req(32'h20, 1'b1, 2'd2, 1'b0, 32'h80FF7F01, 0);
    do_req(32'h21, 1'b0, 2'd0, 1'b0, 32'h0, 0);
    chk("ld_b21_s", last_rdata, 32'h0000007F);
    chk("ld_b21_sel", seen_sel, 4'b0010);
    do_req(32'h23, 1'b0, 2'd0, 1'b0, 32'h0, 0);
    chk("ld_b23_s", last_rdata, 32'hFFFFFF80);
    chk("ld_b23_sel", seen_sel, 4'b1000);
    do_req(32'h23, 1'b0, 2'd0, 1'b1, 32'h0, 0);
    chk("ld_b23_u", last_rdata, 32'h00000080);

    do_req(32'h30, 1'b1, 2'd2, 1'b0, 32'hAAAA5555, 0);
    do_req(32'h32, 1'b1, 2'd1, 1'b0, 32'h00001234, 0);
    chk("st_half_sel", seen_sel, 4'b1100);
    chk("st_half_dat", seen_dat, 32'h12341234);
    do_req(32'h30, 1'b0, 2'd2, 1'b0, 32'h0, 0);
    chk("ld_after_half", last_rdata, 32'h12345555);

    do_req(32'h41, 1'b0, 2'd1, 1'b0, 32'h0, 0);
    chk("mis_half_err", last_err, 3'b001);
    chk("mis_half_lat", last_lat, 1);
    chk("mis_half_cyc", last_cyc, 0);
    do_req(32'h42, 1'b1, 2'd2, 1'b0, 32'h11223344, 0);
    chk("mis_word_err", last_err, 3'b001);
    chk("mis_word_cyc", last_cyc, 0);
    do_req(32'h40, 1'b0, 2'd3, 1'b0, 32'h0, 0);
    chk("rsvd_size_err", last_err, 3'b001);

    slave_mode = 1;
    do_req(32'h50, 1'b0, 2'd2, 1'b0, 32'h0, 0);
    chk("bus_err_code", last_err, 3'b010);
    chk("bus_err_rdata", last_rdata, 32'h0);
    slave_mode = 3;
    do_req(32'h10, 1'b0, 2'd2, 1'b0, 32'h0, 0);
    chk("err_over_ack", last_err, 3'b010);

    slave_mode = 0;
    slave_wait = TO - 1;
    do_req(32'h10, 1'b0, 2'd2, 1'b0, 32'h0, 0);
    chk("late_ack_data", last_rdata, 32'hDEADBEEF);
    chk("late_ack_lat", last_lat, TO + 1);
    slave_mode = 2;
    do_req(32'h10, 1'b0, 2'd2, 1'b0, 32'h0, 0);
    chk("timeout_err", last_err, 3'b100);
    chk("timeout_cyc", last_cyc, 8);

    slave_mode = 0;
    slave_wait = 0;
    do_req(32'h20, 1'b0, 2'd2, 1'b0, 32'h0, 5);
    chk("bp_data", last_rdata, 32'h80FF7F01);

    stray_ack = 1'b1;
    stray_err = 1'b1;
    repeat (3) @(negedge clk);
    stray_ack = 1'b0;
    stray_err = 1'b0;
    chk("stray_no_rsp", rsp_valid_o, 1'b0);
    chk("stray_ready", req_ready_o, 1'b1);

    // Reset in the middle of a bus cycle on a silent slave.
    slave_mode = 2;
    model(32'h60, 1'b0, 2'd2, 1'b0, 32'h0);
    req_valid_i    = 1'b1;
    req_addr_i     = 32'h60;
    req_we_i       = 1'b0;
    req_size_i     = 2'd2;
    req_unsigned_i = 1'b0;
    txn_active     = 1'b1;
    @(negedge clk);
    req_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("cyc_before_rst", bus.cyc, 1'b1);
    #2 rst_i = 1'b1;
    #1;
    chk("rst_mid_cyc", bus.cyc, 1'b0);
    chk("rst_mid_stb", bus.stb, 1'b0);
    chk("rst_mid_ready", req_ready_o, 1'b1);
    @(negedge clk);
    rst_i      = 1'b0;
    txn_active = 1'b0;
    slave_mode = 0;
    rsp_seen   = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rsp_valid_o || bus.cyc) rsp_seen++;
    end
    chk("rst_no_response", rsp_seen, 0);

    for (int t = 0; t < 200; t++) begin
      r  = $urandom_range(0, 9);
      sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      r  = $urandom_range(0, 19);
      if (r < 16) begin
        slave_mode = 0;
        slave_wait = $urandom_range(0, 9);
      end else if (r < 18) begin
        slave_mode = 1;
      end else if (r < 19) begin
        slave_mode = 3;
      end else begin
        slave_mode = 2;
      end
      do_req(32'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), sz,
             1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_lsu_master.md
Name: wb_lsu_master

Overview:
- Wishbone master adapter between the core's load/store unit and the shared wb_bus_t interconnect.
- The interconnect is terminated by the RAM wrapper's wb_slave.
- Converts a core request into one classic single Wishbone cycle. Core request fields: address, size, signedness, write data.
- Byte-lane steering: byte-enables and write-data lanes on the way out; read-data extraction with sign/zero extension on the way back.
- Also reports alignment errors, bus errors and timeout errors to the core.

Parameters:
- TIMEOUT, 255: bus cycles to wait for ack/err before aborting; 0 disables the timeout.
- ADDR_W, 32: address width on core side and bus.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- req_valid_i  in  1  core request valid
- req_ready_o  out  1  adapter can accept a request
- req_addr_i  in  ADDR_W  byte address
- req_we_i  in  1  1 = store, 0 = load
- req_size_i  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_unsigned_i  in  1  loads: 1 = zero-extend, 0 = sign-extend
- req_wdata_i  in  32  store data, LSB-aligned
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  core accepts response
- rsp_rdata_o  out  32  extended load data; 0 for stores and errors
- rsp_err_o  out  3  {timeout, bus_err, misaligned}; 000 = success
- wb_bus  modport wb_bus_t.master  1  cyc, stb, we, sel[3:0], adr, dat out, dat in, ack, err

Behaviour:
- Reset is asynchronous, active-high on rst_i; all state uses the single clock clk_i.
- Reset values:
  - state = IDLE, req_ready_o = 1, rsp_valid_o = 0, rsp_rdata_o = 0, rsp_err_o = 0.
  - cyc = stb = we = 0, sel = 0, adr = 0, dat out = 0, timeout counter = 0.
- FSM has three states: IDLE, BUS, RESP.
- IDLE:
  - req_ready_o = 1. A request is accepted on req_valid_i & req_ready_o; all request fields are registered.
  - Alignment check:
    - half requires addr[0] = 0.
    - word requires addr[1:0] = 00.
    - size 11 is always misaligned.
  - Misaligned: go to RESP with err = 001. No bus cycle is started.
  - Aligned: go to BUS. cyc, stb, we, adr, sel and dat are registered, so they are visible the cycle after acceptance.
- Bus field encoding in BUS:
  - adr = {addr[ADDR_W-1:2], 2'b00}.
  - sel: byte = 0001 << addr[1:0]; half = 0011 << addr[1:0]; word = 1111.
  - dat out:
    - byte = wdata[7:0] replicated on all lanes.
    - half = wdata[15:0] replicated on both halves.
    - word = wdata.
  - we = 0 for loads; sel still drives the accessed lanes.
- BUS:
  - cyc, stb and all bus fields stay constant. The timeout counter increments each cycle.
  - ack sampled high:
    - Capture the read lane: byte = dat_in >> (8*addr[1:0]), half = dat_in >> (16*addr[1]).
    - Extend per size and req_unsigned_i. Stores return 0.
    - Drop cyc/stb, go to RESP with err = 000.
  - err sampled high (priority over ack if both are high): rdata = 0, err = 010, RESP.
  - TIMEOUT != 0 and counter == TIMEOUT-1 with no ack/err: drop cyc/stb, rdata = 0, err = 100, RESP.
  - Counter clears on entry to BUS.
- RESP:
  - rsp_valid_o = 1; rdata and err are held stable until rsp_ready_i.
  - On handshake, go to IDLE; req_ready_o returns to 1 in the following cycle.
  - No request overlap: req_ready_o = 0 in BUS and RESP.
- Latency with a zero-wait slave: accept at cycle T, cyc at T+1, ack at T+1, rsp_valid_o at T+2. Back-to-back throughput is 1 access per 3 cycles.
- Bus rules:
  - cyc == stb at all times; at most one cycle outstanding.
  - cyc drops in the cycle after ack/err/timeout.
  - ack or err arriving while not in BUS is ignored.
- Reset mid-cycle: cyc/stb drop asynchronously and any pending response is discarded.

Decomposition:
- Shared package wb_lsu_pkg holds:
  - typedef lsu_size_e (SIZE_B, SIZE_H, SIZE_W, SIZE_RSVD).
  - typedef lsu_state_e (IDLE, BUS, RESP).
  - Error-bit localparams ERR_MISALIGN, ERR_BUS, ERR_TIMEOUT.
- One natural sub-module: lsu_lane_align, purely combinational. It produces sel and write-data replication from addr/size/wdata, and read extraction and extension from dat_in/addr/size/unsigned.
- The FSM and timeout counter stay in the top module.

Test Plan:
- Word store, then word load, against the RAM wrapper:
  - Store 0xDEADBEEF to 0x10 -> sel = 1111, adr = 0x10, err 000.
  - Load back -> rdata 0xDEADBEEF, rsp_valid_o two cycles after acceptance.
- Signed byte load:
  - Memory word 0x80FF7F01 at 0x20.
  - Byte loads at 0x21 (signed) -> 0x0000007F; 0x23 (signed) -> 0xFFFFFF80; 0x23 (unsigned) -> 0x00000080.
  - sel = 0010 and 1000 respectively.
- Half store at 0x32 of 0x1234 -> sel = 1100, dat = 0x12341234. Word load at 0x30 shows upper half 0x1234, lower half unchanged.
- Misaligned requests: half at 0x41 and word at 0x42 -> err 001, cyc never asserted, rsp_valid_o one cycle after acceptance.
- Bus error and timeout:
  - Slave asserts err -> rsp_err 010, rdata 0.
  - Silent slave with TIMEOUT = 8 -> cyc high exactly 8 cycles, then err 100.
- Response backpressure and reset:
  - Hold rsp_ready_i = 0 for 5 cycles -> rsp stable, req_ready_o = 0.
  - Assert rst_i while cyc = 1 -> cyc/stb drop the same cycle, state IDLE, no response.
